// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU-side blocks of the convolution datapath.
package mcu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHBLK = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Bits needed to hold values 0..v-1, never less than 1 so it can size a vector.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/addr_counter.sv
// Address counter with synchronous clear, enable and terminal-count compare.
module addr_counter #(
  parameter int BITS_ADDR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [BITS_ADDR-1:0] i_last,
  output logic [BITS_ADDR-1:0] o_cnt,
  output logic                 o_tc
);

  logic [BITS_ADDR-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/mcu_seq.sv
// Column sequencer: loads one pixel column into the MCU, sweeps the read
// address with sop/eop markers, then waits out the convolution pipeline.
module mcu_seq
  import mcu_pkg::*;
#(
  parameter int BITS_IMAGEN = 11,
  parameter int BITS_DATA   = BITS_IMAGEN,
  parameter int BITS_ADDR   = 10,
  parameter int PIPE_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [BITS_ADDR-1:0] i_len,
  input  logic [BITS_DATA-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [BITS_DATA-1:0] o_Data,
  output logic                 o_wvalid,
  output logic [BITS_ADDR-1:0] o_WAddr,
  output logic [BITS_ADDR-1:0] o_RAddr,
  output logic                 o_chblk,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int DW = clog2(PIPE_LAT + 1);

  logic [2:0]           r_state, w_nstate;
  logic [BITS_ADDR-1:0] r_len, w_last, w_wcnt, w_rcnt;
  logic [DW-1:0]        r_dcnt;
  logic                 w_start, w_xfer, w_wtc, w_rtc, w_run, w_dlast;
  logic                 r_ready, r_wvalid, r_chblk, r_sop, r_eop, r_busy, r_done;
  logic [BITS_DATA-1:0] r_Data;
  logic [BITS_ADDR-1:0] r_WAddr, r_RAddr;

  assign w_start = (r_state == ST_IDLE) && i_start && (i_len != '0);
  assign w_xfer  = i_valid && r_ready;
  assign w_run   = (r_state == ST_RUN);
  assign w_last  = r_len - 1'b1;
  assign w_dlast = (r_state == ST_DRAIN) && (r_dcnt == DW'(PIPE_LAT));

  addr_counter #(.BITS_ADDR(BITS_ADDR)) u_wcnt (
    .clk(clk), .rst(rst), .i_clr(w_start), .i_en(w_xfer),
    .i_last(w_last), .o_cnt(w_wcnt), .o_tc(w_wtc)
  );

  addr_counter #(.BITS_ADDR(BITS_ADDR)) u_rcnt (
    .clk(clk), .rst(rst), .i_clr(r_state == ST_CHBLK), .i_en(w_run),
    .i_last(w_last), .o_cnt(w_rcnt), .o_tc(w_rtc)
  );

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:  if (w_start)         w_nstate = ST_LOAD;
      ST_LOAD:  if (w_xfer && w_wtc) w_nstate = ST_CHBLK;
      ST_CHBLK:                      w_nstate = ST_RUN;
      ST_RUN:   if (w_rtc)           w_nstate = ST_DRAIN;
      ST_DRAIN: if (w_dlast)         w_nstate = ST_IDLE;
      default:                       w_nstate = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_dcnt   <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_wvalid <= 1'b0;
      r_Data   <= '0;
      r_WAddr  <= '0;
      r_RAddr  <= '0;
      r_chblk  <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_ready  <= (w_nstate == ST_LOAD);
      r_busy   <= (w_nstate != ST_IDLE);
      r_wvalid <= w_xfer;
      r_chblk  <= (r_state == ST_CHBLK);
      r_sop    <= w_run && (w_rcnt == '0);
      r_eop    <= w_run && w_rtc;
      r_done   <= w_dlast;
      r_dcnt   <= (r_state == ST_DRAIN) ? r_dcnt + 1'b1 : '0;
      if (w_start) r_len <= i_len;
      if (w_xfer) begin
        r_Data  <= i_data;
        r_WAddr <= w_wcnt;
      end
      if (w_run) r_RAddr <= w_rcnt;
    end
  end

  assign o_ready  = r_ready;
  assign o_Data   = r_Data;
  assign o_wvalid = r_wvalid;
  assign o_WAddr  = r_WAddr;
  assign o_RAddr  = r_RAddr;
  assign o_chblk  = r_chblk;
  assign o_sop    = r_sop;
  assign o_eop    = r_eop;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_mcu_seq.sv
// Directed bench for mcu_seq: load/sweep/drain timing, gaps, len=1, ignored commands, async reset.
module tb_mcu_seq;

  logic        clk, rst, i_start, i_valid;
  logic [9:0]  i_len;
  logic [10:0] i_data;
  logic        o_ready, o_wvalid, o_chblk, o_sop, o_eop, o_busy, o_done;
  logic [10:0] o_Data;
  logic [9:0]  o_WAddr, o_RAddr;

  int n_tests = 0;
  int n_fail  = 0;

  mcu_seq #(.BITS_IMAGEN(11), .BITS_DATA(11), .BITS_ADDR(10), .PIPE_LAT(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .o_Data(o_Data), .o_wvalid(o_wvalid),
    .o_WAddr(o_WAddr), .o_RAddr(o_RAddr), .o_chblk(o_chblk), .o_sop(o_sop),
    .o_eop(o_eop), .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({o_ready, o_wvalid, o_chblk, o_sop, o_eop, o_busy, o_done}) |
           32'(o_Data) | 32'(o_WAddr) | 32'(o_RAddr);
  endfunction

  initial begin
    int n_wv, n_done, n_eop, n_sop, eop_addr;
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_len = '0; i_data = '0;
    tick(); tick();
    chk("reset_outputs_zero", all_out(), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_addr", 32'(o_WAddr) | 32'(o_RAddr), 32'd0);
    end

    // Single column, len=4, continuous valid
    i_start = 1'b1; i_len = 10'd4;
    tick();
    chk("c1_busy", 32'(o_busy), 32'd1);
    chk("c1_ready", 32'(o_ready), 32'd1);
    i_start = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data = 11'(5 + k);
      tick();
      chk("c1_wvalid", 32'(o_wvalid), 32'd1);
      chk("c1_data", 32'(o_Data), 32'(5 + k));
      chk("c1_waddr", 32'(o_WAddr), 32'(k));
      chk("c1_chblk_early", 32'(o_chblk), 32'd0);
    end
    chk("c1_ready_off", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    tick();
    chk("c1_chblk", 32'(o_chblk), 32'd1);
    chk("c1_wvalid_off", 32'(o_wvalid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("c1_raddr", 32'(o_RAddr), 32'(k));
      chk("c1_sop", 32'(o_sop), (k == 0) ? 32'd1 : 32'd0);
      chk("c1_eop", 32'(o_eop), (k == 3) ? 32'd1 : 32'd0);
      chk("c1_chblk_pulse", 32'(o_chblk), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("c1_drain_done", 32'(o_done), 32'd0);
      chk("c1_drain_busy", 32'(o_busy), 32'd1);
    end
    tick();
    chk("c1_done", 32'(o_done), 32'd1);
    chk("c1_busy_off", 32'(o_busy), 32'd0);
    chk("c1_raddr_hold", 32'(o_RAddr), 32'd3);
    chk("c1_waddr_hold", 32'(o_WAddr), 32'd3);
    tick();
    chk("c1_done_pulse", 32'(o_done), 32'd0);

    // Back-pressure gaps, len=3, valid 1,0,1,0,1
    i_start = 1'b1; i_len = 10'd3;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_valid = (k % 2 == 0); i_data = 11'(10 + k);
      tick();
      chk("bp_wvalid", 32'(o_wvalid), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) begin
        chk("bp_waddr", 32'(o_WAddr), 32'(k / 2));
        chk("bp_data", 32'(o_Data), 32'(10 + k));
      end
      chk("bp_no_chblk", 32'(o_chblk), 32'd0);
    end
    i_valid = 1'b0;
    tick();
    chk("bp_chblk", 32'(o_chblk), 32'd1);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin tick(); n_done += int'(o_done); end
    chk("bp_done_count", 32'(n_done), 32'd1);

    // len=1
    i_start = 1'b1; i_len = 10'd1;
    tick();
    i_start = 1'b0; i_valid = 1'b1; i_data = 11'd9;
    tick();
    chk("l1_wvalid", 32'(o_wvalid), 32'd1);
    chk("l1_waddr", 32'(o_WAddr), 32'd0);
    chk("l1_data", 32'(o_Data), 32'd9);
    i_valid = 1'b0;
    tick();
    chk("l1_chblk", 32'(o_chblk), 32'd1);
    tick();
    chk("l1_sop_eop", 32'({o_sop, o_eop}), 32'd3);
    chk("l1_raddr", 32'(o_RAddr), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("l1_not_done_yet", 32'(o_done), 32'd0);
    tick();
    chk("l1_done", 32'(o_done), 32'd1);

    // len=0 start ignored
    i_start = 1'b1; i_len = 10'd0;
    tick();
    chk("len0_busy", 32'(o_busy), 32'd0);
    chk("len0_ready", 32'(o_ready), 32'd0);
    i_start = 1'b0;
    tick();

    // i_start and i_valid during RUN are ignored
    i_start = 1'b1; i_len = 10'd4;
    tick();
    i_start = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin i_data = 11'(30 + k); tick(); end
    i_valid = 1'b0;
    tick();
    tick();
    chk("ign_in_run_sop", 32'(o_sop), 32'd1);
    i_start = 1'b1; i_len = 10'd2; i_valid = 1'b1; i_data = 11'd99;
    tick();
    tick();
    i_start = 1'b0; i_valid = 1'b0;
    n_wv = 0; n_done = 0; n_eop = 0; eop_addr = -1;
    for (int k = 0; k < 25; k++) begin
      tick();
      n_wv += int'(o_wvalid); n_done += int'(o_done); n_eop += int'(o_eop);
      if (o_eop) eop_addr = int'(o_RAddr);
    end
    chk("ign_no_wvalid", 32'(n_wv), 32'd0);
    chk("ign_one_done", 32'(n_done), 32'd1);
    chk("ign_eop_count", 32'(n_eop), 32'd1);
    chk("ign_eop_addr", 32'(eop_addr), 32'd3);
    chk("ign_not_queued", 32'(o_busy), 32'd0);
    chk("ign_data_kept", 32'(o_Data), 32'd33);

    // Reset in the middle of RUN
    i_start = 1'b1; i_len = 10'd4;
    tick();
    i_start = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin i_data = 11'(40 + k); tick(); end
    i_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mr_raddr2", 32'(o_RAddr), 32'd2);
    rst = 1'b1;
    #1;
    chk("mr_async_zero", all_out(), 32'd0);
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin tick(); n_done += int'(o_done); end
    chk("mr_no_done", 32'(n_done), 32'd0);
    chk("mr_idle", 32'(o_busy), 32'd0);

    // Fresh column len=2 after the abort
    i_start = 1'b1; i_len = 10'd2;
    tick();
    i_start = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_data = 11'(20 + k);
      tick();
      chk("fr_waddr", 32'(o_WAddr), 32'(k));
      chk("fr_data", 32'(o_Data), 32'(20 + k));
    end
    i_valid = 1'b0;
    tick();
    chk("fr_chblk", 32'(o_chblk), 32'd1);
    tick();
    chk("fr_sop", 32'({o_sop, o_eop}), 32'd2);
    chk("fr_raddr0", 32'(o_RAddr), 32'd0);
    tick();
    chk("fr_eop", 32'({o_sop, o_eop}), 32'd1);
    chk("fr_raddr1", 32'(o_RAddr), 32'd1);
    n_sop = 0;
    for (int k = 0; k < 4; k++) begin tick(); n_sop += int'(o_done); end
    chk("fr_done_early", 32'(n_sop), 32'd0);
    tick();
    chk("fr_done", 32'(o_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
